// File: rtl/dense_cmd_encoder.sv
// Dense-layer command issuer: turns one packed command plus data beats into registered decode fields and strobes.
// Optional sticky error flag (err / err_clr) is enabled with the DENSE_ENC_ERR_EN macro.
module dense_cmd_encoder #(
  parameter int unsigned size            = 3,
  parameter int unsigned data_size       = 16,
  parameter int unsigned cost_type_size  = 8,
  parameter int unsigned dense_type_size = 4,
  parameter int unsigned act_type_size   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [31:0]                   cmd_layer,
  input  logic [31:0]                   cmd_rows,
  input  logic [act_type_size-1:0]      cmd_act_type,
  input  logic [dense_type_size-1:0]    cmd_dense_type,
  input  logic [cost_type_size-1:0]     cmd_cost_type,
  input  logic                          data_valid,
  output logic                          data_ready,
  input  logic [data_size*size-1:0]     data_in,
  output logic [act_type_size-1:0]      act_type_out,
  output logic [dense_type_size-1:0]    dense_type_out,
  output logic [cost_type_size-1:0]     cost_type_out,
  output logic [data_size*size-1:0]     w_out,
  output logic [31:0]                   w_layer_index_out,
  output logic [31:0]                   w_row_index_out,
  output logic                          load_w_out,
  output logic                          backprop_cost_out,
  output logic                          is_update_out,
  output logic [data_size*size-1:0]     x_out,
  output logic [data_size*size-1:0]     label_out,
  output logic                          out_valid
`ifdef DENSE_ENC_ERR_EN
  ,
  output logic                          err,
  input  logic                          err_clr
`endif
);

  localparam int unsigned VEC_W = data_size * size;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FWD   = 3'd2,
    BPROP = 3'd3,
    UPD   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] layer_q;
  logic [31:0] rows_q;
  logic [31:0] row_cnt;
  logic        cmd_fire;
  logic        data_fire;
  logic        last_row;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign data_fire = data_valid && data_ready;
  assign last_row  = (row_cnt == rows_q - 32'd1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          case (cmd_op)
            2'd0:    state_nxt = (cmd_rows != 32'd0) ? LOAD : IDLE;
            2'd1:    state_nxt = FWD;
            2'd2:    state_nxt = BPROP;
            default: state_nxt = UPD;
          endcase
        end
      end
      LOAD:    if (data_fire && last_row) state_nxt = IDLE;
      FWD:     if (data_fire) state_nxt = IDLE;
      BPROP:   if (data_fire) state_nxt = IDLE;
      UPD:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake readies are registered from the next state so they track the FSM and are low in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready  <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      cmd_ready  <= (state_nxt == IDLE);
      data_ready <= (state_nxt == LOAD) || (state_nxt == FWD) || (state_nxt == BPROP);
    end
  end

  // Command latch and row counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_q        <= 32'd0;
      rows_q         <= 32'd0;
      row_cnt        <= 32'd0;
      act_type_out   <= '0;
      dense_type_out <= '0;
      cost_type_out  <= '0;
    end else if (cmd_fire) begin
      layer_q        <= cmd_layer;
      rows_q         <= cmd_rows;
      row_cnt        <= 32'd0;
      act_type_out   <= cmd_act_type;
      dense_type_out <= cmd_dense_type;
      cost_type_out  <= cmd_cost_type;
    end else if (data_fire && (state == LOAD)) begin
      row_cnt        <= row_cnt + 32'd1;
    end
  end

  // Issued fields: strobes pulse for one cycle, data/index fields hold their last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_out             <= VEC_W'(0);
      w_layer_index_out <= 32'd0;
      w_row_index_out   <= 32'd0;
      x_out             <= VEC_W'(0);
      label_out         <= VEC_W'(0);
      load_w_out        <= 1'b0;
      backprop_cost_out <= 1'b0;
      is_update_out     <= 1'b0;
      out_valid         <= 1'b0;
    end else begin
      load_w_out        <= 1'b0;
      backprop_cost_out <= 1'b0;
      is_update_out     <= 1'b0;
      out_valid         <= 1'b0;
      case (state)
        LOAD: if (data_fire) begin
          w_out             <= data_in;
          w_layer_index_out <= layer_q;
          w_row_index_out   <= row_cnt;
          load_w_out        <= 1'b1;
          out_valid         <= 1'b1;
        end
        FWD: if (data_fire) begin
          x_out     <= data_in;
          out_valid <= 1'b1;
        end
        BPROP: if (data_fire) begin
          label_out         <= data_in;
          backprop_cost_out <= 1'b1;
          out_valid         <= 1'b1;
        end
        UPD: begin
          is_update_out <= 1'b1;
          out_valid     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DENSE_ENC_ERR_EN
  logic err_set;
  assign err_set = (cmd_fire && (cmd_op == 2'd0) && (cmd_rows == 32'd0)) ||
                   (data_valid && (state == IDLE));

  // Sticky error; a set event wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_dense_cmd_encoder.sv
// Scoreboard bench for dense_cmd_encoder: stimulus pushes expected issue snapshots, a monitor pops and compares.
module tb_dense_cmd_encoder;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_layer;
  logic [31:0] cmd_rows;
  logic [3:0]  cmd_act_type;
  logic [3:0]  cmd_dense_type;
  logic [7:0]  cmd_cost_type;
  logic        data_valid;
  logic        data_ready;
  logic [47:0] data_in;
  logic [3:0]  act_type_out;
  logic [3:0]  dense_type_out;
  logic [7:0]  cost_type_out;
  logic [47:0] w_out;
  logic [31:0] w_layer_index_out;
  logic [31:0] w_row_index_out;
  logic        load_w_out;
  logic        backprop_cost_out;
  logic        is_update_out;
  logic [47:0] x_out;
  logic [47:0] label_out;
  logic        out_valid;
`ifdef DENSE_ENC_ERR_EN
  logic        err;
  logic        err_clr;
`endif

  dense_cmd_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_layer(cmd_layer), .cmd_rows(cmd_rows), .cmd_act_type(cmd_act_type),
    .cmd_dense_type(cmd_dense_type), .cmd_cost_type(cmd_cost_type),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .act_type_out(act_type_out), .dense_type_out(dense_type_out),
    .cost_type_out(cost_type_out), .w_out(w_out),
    .w_layer_index_out(w_layer_index_out), .w_row_index_out(w_row_index_out),
    .load_w_out(load_w_out), .backprop_cost_out(backprop_cost_out),
    .is_update_out(is_update_out), .x_out(x_out), .label_out(label_out),
    .out_valid(out_valid)
`ifdef DENSE_ENC_ERR_EN
    , .err(err), .err_clr(err_clr)
`endif
  );

  typedef struct packed {
    logic [47:0] w;
    logic [31:0] layer;
    logic [31:0] row;
    logic        lw;
    logic        bp;
    logic        upd;
    logic [47:0] x;
    logic [47:0] label;
    logic [3:0]  act;
    logic [3:0]  dense;
    logic [7:0]  cost;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m;
  logic [1:0]  m_op;
  logic [31:0] m_layer;
  logic [31:0] m_row;
  int          vectors;
  int          miscompares;
  int          lw_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare every issued cycle with the next expected snapshot; strobes must be quiet otherwise
  always @(posedge clk) begin
    exp_t got, e;
    #1;
    got = '{w_out, w_layer_index_out, w_row_index_out, load_w_out, backprop_cost_out,
            is_update_out, x_out, label_out, act_type_out, dense_type_out, cost_type_out};
    if (load_w_out) lw_cnt++;
    vectors++;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_issue: got out_valid=1 expected no pending issue");
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL issue_fields: got %h expected %h", got, e);
        end
      end
    end else if (load_w_out || backprop_cost_out || is_update_out) begin
      miscompares++;
      $display("FAIL idle_strobes: got lw/bp/upd=%b%b%b expected 000",
               load_w_out, backprop_cost_out, is_update_out);
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] layer, input logic [31:0] rows,
                          input logic [3:0] act, input logic [3:0] dense, input logic [7:0] cost);
    int n;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_layer = layer; cmd_rows = rows;
    cmd_act_type = act; cmd_dense_type = dense; cmd_cost_type = cost;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    m.act = act; m.dense = dense; m.cost = cost;
    m_op = op; m_layer = layer; m_row = 32'd0;
    if (op == 2'd3) begin
      e = m; e.upd = 1'b1;
      exp_q.push_back(e);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [47:0] d, input int gap);
    int n;
    exp_t e;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    data_valid = 1'b1; data_in = d;
    n = 0;
    while (!data_ready && n < 50) begin @(negedge clk); n++; end
    if (!data_ready) chk("data_ready_timeout", 64'(data_ready), 64'd1);
    @(posedge clk);
    case (m_op)
      2'd0: begin m.w = d; m.layer = m_layer; m.row = m_row; m_row++; end
      2'd1: m.x = d;
      default: m.label = d;
    endcase
    e = m;
    e.lw = (m_op == 2'd0);
    e.bp = (m_op == 2'd2);
    exp_q.push_back(e);
    #1 data_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 64'(|{act_type_out, dense_type_out, cost_type_out, w_out, w_layer_index_out,
                    w_row_index_out, load_w_out, backprop_cost_out, is_update_out,
                    x_out, label_out, out_valid}), 64'd0);
    chk({name, "_ready"}, 64'({cmd_ready, data_ready}), 64'd0);
  endtask

  initial begin
    int lw_base;
    int n;
    vectors = 0; miscompares = 0; lw_cnt = 0;
    m = '0; m_op = 2'd0; m_layer = 32'd0; m_row = 32'd0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_layer = 32'd0; cmd_rows = 32'd0;
    cmd_act_type = 4'd0; cmd_dense_type = 4'd0; cmd_cost_type = 8'd0;
    data_valid = 1'b0; data_in = 48'd0;
`ifdef DENSE_ENC_ERR_EN
    err_clr = 1'b0;
`endif
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset with random inputs toggling
    repeat (4) begin
      @(negedge clk);
      cmd_valid = 1'($urandom); cmd_op = 2'($urandom); cmd_layer = $urandom;
      cmd_rows = $urandom; cmd_act_type = 4'($urandom); data_valid = 1'($urandom);
      data_in = 48'({$urandom, $urandom});
      #1 chk_all_zero("reset_outputs");
    end
    @(negedge clk);
    cmd_valid = 1'b0; data_valid = 1'b0; cmd_op = 2'd0; cmd_rows = 32'd0;
    cmd_layer = 32'd0; cmd_act_type = 4'd0; data_in = 48'd0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 64'(cmd_ready), 64'd1);

    // LOAD_W layer 2, three rows back-to-back
    lw_base = lw_cnt;
    send_cmd(2'd0, 32'd2, 32'd3, 4'd2, 4'd3, 8'h11);
    send_beat(48'hAAAA_0000_0001, 0);
    send_beat(48'hBBBB_0000_0002, 0);
    send_beat(48'hCCCC_0000_0003, 0);
    wait_drain();
    chk("load3_pulses", 64'(lw_cnt - lw_base), 64'd3);
    chk("load3_cmd_ready", 64'(cmd_ready), 64'd1);

    // LOAD_W rows=4 with a 2-cycle stall after row 1
    lw_base = lw_cnt;
    send_cmd(2'd0, 32'd7, 32'd4, 4'd4, 4'd5, 8'h22);
    send_beat(48'h1111_1111_1111, 0);
    send_beat(48'h2222_2222_2222, 0);
    send_beat(48'h3333_3333_3333, 2);
    send_beat(48'h4444_4444_4444, 0);
    wait_drain();
    chk("load4_pulses", 64'(lw_cnt - lw_base), 64'd4);
    chk("load4_row_index", 64'(w_row_index_out), 64'd3);

    // FORWARD then BACKPROP; x must hold across the backprop issue
    send_cmd(2'd1, 32'd1, 32'd0, 4'd6, 4'd7, 8'h33);
    send_beat(48'h0001_0002_0003, 0);
    send_cmd(2'd2, 32'd1, 32'd0, 4'd6, 4'd7, 8'h44);
    send_beat(48'h0004_0005_0006, 0);
    wait_drain();
    chk("x_held", 64'(x_out), 64'h0001_0002_0003);
    chk("label_held", 64'(label_out), 64'h0004_0005_0006);

    // UPDATE: no data consumed, act code latched and held
    send_cmd(2'd3, 32'd0, 32'd0, 4'd1, 4'd2, 8'h55);
    data_valid = 1'b1; data_in = 48'hDEAD_BEEF_0000;
    @(negedge clk);
    chk("upd_data_ready", 64'(data_ready), 64'd0);
    data_valid = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    chk("upd_act_held", 64'(act_type_out), 64'd1);
    chk("upd_strobe_cleared", 64'(is_update_out), 64'd0);

    // Reset asserted mid-LOAD after rows 0 and 1 of 3
    send_cmd(2'd0, 32'd5, 32'd3, 4'd8, 4'd9, 8'h66);
    send_beat(48'h5555_0000_0000, 0);
    send_beat(48'h5555_0000_0001, 0);
    wait_drain();
    rst_n = 1'b0;
    #1 chk_all_zero("midload_reset");
    exp_q.delete();
    m = '0; m_op = 2'd0; m_layer = 32'd0; m_row = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!cmd_ready && n < 10) begin @(negedge clk); n++; end
    chk("post_reset_idle", 64'({cmd_ready, data_ready}), 64'b10);

    // Fresh op after reset issues on top of cleared fields
    send_cmd(2'd1, 32'd9, 32'd0, 4'd3, 4'd3, 8'h77);
    send_beat(48'h0ABC_0DEF_0123, 0);
    wait_drain();

`ifdef DENSE_ENC_ERR_EN
    chk("err_clear_initially", 64'(err), 64'd0);
    send_cmd(2'd0, 32'd4, 32'd0, 4'd1, 4'd1, 8'h01);
    @(negedge clk);
    chk("err_set_rows0", 64'(err), 64'd1);
    chk("rows0_stays_idle", 64'(cmd_ready), 64'd1);
    repeat (2) @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", 64'(err), 64'd0);
`endif

    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
